uart_tx_fsm: RTL and testbench
==============================

# uart_tx_fsm

Serial transmitter for the UART link: accepts a parallel word over a valid/ready handshake and emits a frame of start bit, data bits MSB first, an optional even-parity bit and stop bits on `Tx_Out`. It is the far end of the receiver FSM on the same line. It honours the receiver's `RTS` through its own `CTS` input, and its frame format matches the receiver's bit-for-bit.

## Interface
- `DATA_BITS`, 8, data bits per frame.
- `STOP_BITS`, 2, stop bits per frame; minimum 1.
- `PARITY_BIT`, 1, 1 sends an even-parity bit (XOR of all data bits); 0 omits the parity state.
- `CLKS_PER_BIT`, 1, clock cycles per bit time; minimum 1. A value of 1 matches the receiver's one-bit-per-clock sampling.

Ports:
- `Clk`  in  1  single clock; everything is on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Tx_Valid`  in  1  request to send `Tx_Data_In`.
- `Tx_Data_In`  in  DATA_BITS  word to send.
- `CTS`  in  1  far end ready; connect to the receiver's `RTS`.
- `Tx_Ready`  out  1  transmitter can accept a word.
- `Tx_Out`  out  1  serial line; idle high.
- `Tx_Busy`  out  1  frame in progress.
- `Tx_Done_Out`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: Ready, Start_Bit, Tx_Data, Parity, Stop_Bit, Tx_Done. Each state except Ready lasts exactly `CLKS_PER_BIT` cycles per bit it sends.
- Ready
  - `Tx_Ready = CTS` in this state only.
  - Accept when `Tx_Valid & Tx_Ready` at a clock edge; latch `Tx_Data_In` into the shift register and go to Start_Bit.
- Start_Bit: `Tx_Out = 0`.
- Tx_Data
  - Send `shift[DATA_BITS-1]`, then shift left.
  - The bit counter runs 0..DATA_BITS-1; leave the state after bit DATA_BITS-1.
  - Next state is Parity if `PARITY_BIT = 1`, otherwise Stop_Bit.
- Parity
  - Parity is computed from the latched word at acceptance, not from the shifting register.
  - `Tx_Out = ^data`.
- Stop_Bit: `Tx_Out = 1` for `STOP_BITS` bit times.
- Tx_Done
  - `Tx_Out = 1` for one bit time, a guaranteed idle gap.
  - `Tx_Done_Out` pulses in the last cycle of this state.
  - Next state is Ready.
- `Tx_Busy = 1` in every state except Ready.
- `Tx_Out` is registered, with no glitches.
- Boundary behaviour:
  - `Tx_Data_In` changes after acceptance are ignored.
  - `Tx_Valid` while busy is ignored; the requester holds it until `Tx_Ready`.
  - `CTS` low in Ready: no acceptance, line stays idle.
  - `CTS` dropping mid-frame does not abort the frame.
  - `Rst` low at any time forces state Ready immediately, clears all counters and the shift register, `Tx_Out = 1`, `Tx_Busy = 0`, `Tx_Done_Out = 0`. `Tx_Ready` follows `CTS` once `Rst` is high.

## Timing
- Reset values: `Tx_Out = 1`, `Tx_Busy = 0`, `Tx_Done_Out = 0`, `Tx_Ready = 0` while `Rst` is low.
- Latency: acceptance at edge N puts the start bit on `Tx_Out` from cycle N+1 for `CLKS_PER_BIT` cycles.
- Data bit k (MSB is k = 0) occupies cycles N+1+(1+k)·CLKS_PER_BIT onward.
- Frame length is (1 + DATA_BITS + PARITY_BIT + STOP_BITS + 1) · CLKS_PER_BIT cycles from N+1 to the `Tx_Done_Out` pulse inclusive. Defaults give 13 cycles.
- Back-to-back: the earliest next acceptance is the cycle after the return to Ready. The next start bit therefore follows at least one idle bit time plus one cycle after the last stop bit, which gives the receiver's Rx_Done/Ready recovery.
- Bit-time counter: width `$clog2(CLKS_PER_BIT)` with a minimum of 1; it wraps to 0 at every bit boundary.
- Bit counter and stop counter widths are `$clog2` of their limits plus 1. No overflow is possible.

## Structure
- Shared package `uart_pkg` holds:
  - typedef `Tx_States` (enum `logic [2:0]`);
  - the idle-level constant;
  - function `frame_bits(DATA_BITS, PARITY_BIT, STOP_BITS)` for the frame length.
- One sub-module `uart_baud_tick` (parameter `CLKS_PER_BIT`): outputs `Bit_Tick` on the last cycle of each bit time. It restarts on frame acceptance and is held cleared in Ready.
- FSM, shift register and counters live in `uart_tx_fsm`.

## Test plan
- Defaults, `CTS = 1`, send 0xA5: `Tx_Out` = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1,1, then 1 (done). `Tx_Done_Out` pulses at cycle N+13.
- Send 0x07: parity bit is 1. With `PARITY_BIT = 0`, no parity bit, frame is 12 cycles.
- `CTS = 0` with `Tx_Valid = 1` for 20 cycles: `Tx_Ready = 0`, `Tx_Out` stays 1. Raise `CTS`: acceptance within 1 cycle.
- `Rst` low during data bit 3: `Tx_Out = 1` and `Tx_Busy = 0` without waiting for a clock edge. After release, sending 0x3C gives a clean frame.
- `CLKS_PER_BIT = 4`, send 0x81: each bit is held for 4 cycles, total 52 cycles to `Tx_Done_Out`.
- Loopback into the receiver FSM (`Tx_Out` to `Rx_In`, `RTS` to `CTS`): 256 back-to-back words 0x00–0xFF. Each word appears on `Rx_Data_Out` with `Data_Rdy_Out = 1` and `Rx_Error = 0`, except 0x00, which the bench must check against the receiver's break-detect rule.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level
// and the frame-length helper used by both ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    READY,
    START_BIT,
    TX_DATA,
    PARITY,
    STOP_BIT,
    TX_DONE
  } Tx_States;

  localparam logic IDLE_LEVEL = 1'b1;

  // Bit times per frame, including the trailing idle gap.
  function automatic int frame_bits(input int data_bits, input int parity_bit,
                                    input int stop_bits);
    return 1 + data_bits + parity_bit + stop_bits + 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: Bit_Tick marks the last cycle of each bit time, Pre_Tick the cycle before it.
// Held at zero while Clear is high so every frame starts on a fresh bit boundary.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clear,
  output logic Bit_Tick,
  output logic Pre_Tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_cnt;

  assign Bit_Tick = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign Pre_Tick = (CLKS_PER_BIT > 1) && (r_cnt == CW'(CLKS_PER_BIT - 2));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt <= '0;
    end else if (Clear || Bit_Tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, data MSB first, optional even parity, stop bits, one idle bit.
// Start bit appears the cycle after acceptance; Tx_Ready only in Ready and gated by CTS.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 2,
  parameter int PARITY_BIT   = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Tx_Valid,
  input  logic [DATA_BITS-1:0] Tx_Data_In,
  input  logic                 CTS,
  output logic                 Tx_Ready,
  output logic                 Tx_Out,
  output logic                 Tx_Busy,
  output logic                 Tx_Done_Out
);

  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam int SW = $clog2(STOP_BITS) + 1;

  Tx_States             r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [BW-1:0]        r_bit_cnt;
  logic [SW-1:0]        r_stop_cnt;
  logic                 w_tick;
  logic                 w_pre_tick;
  logic                 w_clear;

  assign w_clear  = (r_state == READY);
  assign Tx_Ready = w_clear && CTS && Rst;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk     (Clk),
    .Rst     (Rst),
    .Clear   (w_clear),
    .Bit_Tick(w_tick),
    .Pre_Tick(w_pre_tick)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= READY;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= '0;
      Tx_Out      <= IDLE_LEVEL;
      Tx_Busy     <= 1'b0;
      Tx_Done_Out <= 1'b0;
    end else begin
      case (r_state)
        READY: begin
          if (Tx_Valid && Tx_Ready) begin
            r_shift    <= Tx_Data_In;
            r_parity   <= ^Tx_Data_In;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            Tx_Out     <= 1'b0;
            Tx_Busy    <= 1'b1;
            r_state    <= START_BIT;
          end
        end
        START_BIT: begin
          if (w_tick) begin
            Tx_Out  <= r_shift[DATA_BITS-1];
            r_shift <= r_shift << 1;
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
              if (PARITY_BIT != 0) begin
                Tx_Out  <= r_parity;
                r_state <= PARITY;
              end else begin
                Tx_Out  <= IDLE_LEVEL;
                r_state <= STOP_BIT;
              end
            end else begin
              Tx_Out    <= r_shift[DATA_BITS-1];
              r_shift   <= r_shift << 1;
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            Tx_Out  <= IDLE_LEVEL;
            r_state <= STOP_BIT;
          end
        end
        STOP_BIT: begin
          if (w_tick) begin
            if (r_stop_cnt == SW'(STOP_BITS - 1)) begin
              r_state <= TX_DONE;
              // A single-cycle bit time makes the first Tx_Done cycle also its last.
              Tx_Done_Out <= (CLKS_PER_BIT == 1);
            end else begin
              r_stop_cnt <= r_stop_cnt + SW'(1);
            end
          end
        end
        TX_DONE: begin
          if (w_tick) begin
            Tx_Busy     <= 1'b0;
            Tx_Done_Out <= 1'b0;
            r_state     <= READY;
          end else begin
            Tx_Done_Out <= w_pre_tick;
          end
        end
        default: begin
          r_state <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: three parameterisations driven cycle by cycle against a frame-list model,
// plus literal frame patterns and frame lengths.
module tb_uart_tx_fsm;

  localparam int NI       = 3;
  localparam int CPB [NI] = '{1, 1, 4};
  localparam int PAR [NI] = '{1, 0, 1};

  logic          clk;
  logic          rst_n;
  logic [NI-1:0] valid;
  logic [NI-1:0] cts;
  logic [7:0]    din [NI];
  logic [NI-1:0] ready;
  logic [NI-1:0] tx_out;
  logic [NI-1:0] busy;
  logic [NI-1:0] done_o;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fsm #(
      .DATA_BITS   (8),
      .STOP_BITS   (2),
      .PARITY_BIT  (PAR[g]),
      .CLKS_PER_BIT(CPB[g])
    ) u_dut (
      .Clk        (clk),
      .Rst        (rst_n),
      .Tx_Valid   (valid[g]),
      .Tx_Data_In (din[g]),
      .CTS        (cts[g]),
      .Tx_Ready   (ready[g]),
      .Tx_Out     (tx_out[g]),
      .Tx_Busy    (busy[g]),
      .Tx_Done_Out(done_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Model: expected line level for each cycle of the current frame.
  logic [63:0] f_tx [NI];
  int          f_len [NI];
  int          f_pos [NI];
  bit          acc [NI];
  logic [63:0] cap_w [NI];
  int          cap_n [NI];
  int          done_at [NI];
  int          words [NI];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_frame(input int g);
    return f_pos[g] < f_len[g];
  endfunction

  function automatic void build(input int g, input logic [7:0] d);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 7; i >= 0; i--) b.push_back(d[i]);
    if (PAR[g] != 0) b.push_back(^d);
    b.push_back(1'b1);
    b.push_back(1'b1);
    b.push_back(1'b1);
    f_len[g] = b.size() * CPB[g];
    f_tx[g]  = '0;
    for (int k = 0; k < f_len[g]; k++) f_tx[g][k] = b[k / CPB[g]];
    f_pos[g] = 0;
  endfunction

  function automatic void model_edge(input int g);
    acc[g] = 1'b0;
    if (!rst_n) begin
      f_len[g] = 0;
      f_pos[g] = 0;
    end else if (in_frame(g)) begin
      f_pos[g]++;
    end else if (valid[g] && cts[g]) begin
      build(g, din[g]);
      acc[g]     = 1'b1;
      cap_w[g]   = '0;
      cap_n[g]   = 0;
      done_at[g] = 0;
    end
  endfunction

  task automatic compare(input int g);
    logic e_tx, e_busy, e_done, e_rdy;
    if (in_frame(g)) begin
      e_tx   = f_tx[g][f_pos[g]];
      e_busy = 1'b1;
      e_done = (f_pos[g] == f_len[g] - 1);
      e_rdy  = 1'b0;
      cap_w[g] = {cap_w[g][62:0], tx_out[g]};
      cap_n[g]++;
      if (done_o[g]) done_at[g] = cap_n[g];
    end else begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_rdy  = rst_n & cts[g];
    end
    chk($sformatf("i%0d_tx", g), 64'(tx_out[g]), 64'(e_tx));
    chk($sformatf("i%0d_busy", g), 64'(busy[g]), 64'(e_busy));
    chk($sformatf("i%0d_done", g), 64'(done_o[g]), 64'(e_done));
    chk($sformatf("i%0d_ready", g), 64'(ready[g]), 64'(e_rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < NI; g++) model_edge(g);
    @(negedge clk);
    for (int g = 0; g < NI; g++) compare(g);
  endtask

  task automatic wait_idle(input int g);
    for (int t = 0; t < 200 && in_frame(g); t++) tick();
    if (in_frame(g)) chk($sformatf("i%0d_idle_timeout", g), 64'd1, 64'd0);
  endtask

  task automatic send(input int g, input logic [7:0] d);
    din[g]   = d;
    valid[g] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (acc[g]) break;
    end
    if (!acc[g]) chk($sformatf("i%0d_accept_timeout", g), 64'd0, 64'd1);
    valid[g] = 1'b0;
    din[g]   = 8'($urandom);
    wait_idle(g);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    valid  = '0;
    cts    = '1;
    for (int g = 0; g < NI; g++) begin
      din[g] = 8'h00; f_len[g] = 0; f_pos[g] = 0; acc[g] = 1'b0;
      cap_w[g] = '0; cap_n[g] = 0; done_at[g] = 0; words[g] = 0;
    end

    repeat (3) tick();
    chk("reset_tx", 64'(tx_out), 64'b111);
    chk("reset_busy", 64'(busy), 64'b000);
    chk("reset_ready", 64'(ready), 64'b000);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 64'(ready), 64'b111);

    send(0, 8'hA5);
    chk("a5_frame", cap_w[0], 64'b0101001010111);
    chk("a5_done_cycle", 64'(done_at[0]), 64'd13);

    send(0, 8'h07);
    chk("07_frame", cap_w[0], 64'b0000001111111);
    send(1, 8'h07);
    chk("07_nopar_frame", cap_w[1], 64'b000000111111);
    chk("07_nopar_done_cycle", 64'(done_at[1]), 64'd12);

    send(2, 8'h81);
    chk("81_cpb4_frame", cap_w[2], 64'h0F000000F0FFF);
    chk("81_cpb4_done_cycle", 64'(done_at[2]), 64'd52);

    // CTS held low blocks acceptance; raising it accepts at the next edge.
    cts[0]   = 1'b0;
    valid[0] = 1'b1;
    din[0]   = 8'h55;
    repeat (20) tick();
    chk("cts_low_busy", 64'(busy[0]), 64'd0);
    chk("cts_low_tx", 64'(tx_out[0]), 64'd1);
    cts[0] = 1'b1;
    tick();
    chk("cts_rise_accept", 64'(busy[0]), 64'd1);
    valid[0] = 1'b0;
    din[0]   = 8'hFF;
    repeat (3) tick();
    cts[0] = 1'b0;
    wait_idle(0);
    chk("cts_drop_frame", cap_w[0], 64'b0010101010111);
    cts[0] = 1'b1;

    // Asynchronous reset during data bit 3.
    din[0]   = 8'hA5;
    valid[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (acc[0]) break;
    end
    valid[0] = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 64'(tx_out[0]), 64'd1);
    chk("async_rst_busy", 64'(busy[0]), 64'd0);
    chk("async_rst_done", 64'(done_o[0]), 64'd0);
    for (int g = 0; g < NI; g++) begin
      f_len[g] = 0;
      f_pos[g] = 0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    send(0, 8'h3C);
    chk("3c_after_rst_frame", cap_w[0], 64'b0001111000111);
    chk("3c_done_cycle", 64'(done_at[0]), 64'd13);

    // Back-to-back words 0x00..0xFF with Tx_Valid held high.
    valid[0] = 1'b1;
    valid[1] = 1'b1;
    din[0]   = 8'h00;
    din[1]   = 8'h00;
    for (int t = 0; t < 10000 && (words[0] < 256 || words[1] < 256); t++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        if (acc[g]) begin
          words[g]++;
          if (words[g] < 256) din[g] = 8'(words[g]);
          else valid[g] = 1'b0;
        end
      end
    end
    if (words[0] < 256 || words[1] < 256) chk("b2b_timeout", 64'(words[0] + words[1]), 64'd512);
    valid = '0;
    wait_idle(0);
    wait_idle(1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
